root_engine_arbiter: RTL and testbench
======================================

Name: root_engine_arbiter

Overview:
- Shares one Q10.10 nth-root engine between NUM_REQ requesters.
- Each request is an integer radicand (10 b) and an exponent (3 b). The block grants one request at a time in round-robin order and drives the engine's in_valid/in_data_1/in_data_2.
- It holds the operands stable for the whole computation and captures the engine's single-cycle out_valid/out_data pulse.
- It returns the result, tagged with the requester ID, on a valid/ready response port. It also guards against exponent 0 and engine hangs.

Parameters:
- NUM_REQ, 4, number of requesters
- ID_W, 2, requester ID width (clog2 NUM_REQ)
- D1_W, 10, radicand width (integer)
- D2_W, 3, exponent width
- OUT_W, 20, result width (Q10.10)
- TIMEOUT, 255, max engine cycles before abort (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- req_data_1  in  NUM_REQ*D1_W  packed radicands; requester i in slice [i*D1_W +: D1_W]
- req_data_2  in  NUM_REQ*D2_W  packed exponents
- eng_in_valid  out  1  engine start pulse
- eng_in_data_1  out  D1_W  engine radicand
- eng_in_data_2  out  D2_W  engine exponent
- eng_out_valid  in  1  engine result pulse
- eng_out_data  in  OUT_W  engine result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  granted requester
- rsp_data  out  OUT_W  Q10.10 root
- rsp_err  out  1  1 = exponent 0 or timeout
- busy  out  1  not in IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, rr_ptr=0, timeout counter 0. The engine is reset by the same top-level reset. A reset mid-operation discards any in-flight request silently.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr (wrapping). Assert req_ready[winner] for exactly this cycle.
  - Latch winner ID, data_1 and data_2.
  - If data_2 == 0, load rsp_data=0, rsp_err=1 and go to RESP; the engine is never issued.
  - Otherwise go to ISSUE.
  - With no req_valid, stay in IDLE with outputs idle.
- ISSUE: eng_in_valid=1 for exactly one cycle; clear the timeout counter; go to BUSY.
- BUSY:
  - eng_in_valid=0. eng_in_data_1/2 hold the latched operands; the engine reads in_data_2 every pow step.
  - On eng_out_valid, capture eng_out_data into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1 with no eng_out_valid, set rsp_data=0, rsp_err=1 and go to RESP. No re-issue.
- RESP:
  - rsp_valid=1. rsp_id/rsp_data/rsp_err are stable until rsp_ready.
  - On rsp_valid && rsp_ready: rr_ptr = winner+1 (mod NUM_REQ), go to IDLE.
  - This gives one bubble cycle before the next grant. req_ready is 0 throughout RESP.
- Operand outputs eng_in_data_1/2 hold their last value outside BUSY (no toggle).
- eng_out_valid arriving in IDLE/ISSUE/RESP (e.g. a late pulse after timeout) is ignored.
- Requesters must hold req_valid/data until req_ready. The block does not require a requester to drop req_valid after acceptance; a held req_valid counts as a new request.
- Fairness: a requester that continuously asserts req_valid is served within NUM_REQ grants.
- Engine contract: the engine is started only by a one-cycle eng_in_valid while idle. Result is Q10.10, 20 b, unsigned. The expected result for exponent 1 is {data_1, 10'b0}.

Decomposition:
- Shared package root_pkg:
  - Q10.10 constants: FRAC_W=10, OUT_W=20.
  - Default D1_W/D2_W.
  - State enum {IDLE, ISSUE, BUSY, RESP}.
  - Timeout counter width.
- Natural sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs req vector and rr_ptr; outputs one-hot grant and encoded winner ID.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Req 0: data_1=4, data_2=2 → one eng_in_valid pulse; rsp_id=0, rsp_data=20'h00800, rsp_err=0.
- Req 2: data_1=8, data_2=3, with rsp_ready held low 10 cycles after rsp_valid → rsp_data=20'h00800 held stable all 10 cycles; IDLE one cycle after accept.
- Req 1: data_1=5, data_2=1 → rsp_data=20'h01400; req 3: data_2=0 → no eng_in_valid, rsp_err=1, rsp_data=0, within 3 cycles of req_ready.
- All 4 req_valid high continuously from reset → grant order 0,1,2,3,0; each req_ready is a single-cycle one-hot pulse.
- Engine stub that never asserts out_valid → rsp_err=1 exactly TIMEOUT cycles after ISSUE; a late eng_out_valid injected in IDLE is ignored.
- rst asserted mid-BUSY → all outputs 0 asynchronously; next request after release is granted starting from requester 0.

Source files
------------

// File: rtl/root_pkg.sv
// Shared constants and types for the nth-root engine arbiter.
package root_pkg;

  // Q10.10 result format
  localparam int unsigned QIntW  = 10;
  localparam int unsigned QFracW = 10;
  localparam int unsigned QOutW  = QIntW + QFracW;

  // Default request operand widths
  localparam int unsigned DefD1W = 10;
  localparam int unsigned DefD2W = 3;

  // Engine watchdog
  localparam int unsigned TmoCntW    = 8;
  localparam int unsigned DefTimeout = 255;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_w;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!any_o && req_i[idx_w]) begin
        gnt_o[idx_w] = 1'b1;
        id_o         = idx_w;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/root_engine_arbiter.sv
// Shares one Q10.10 nth-root engine between NUM_REQ requesters in round-robin order.
// Exponent 0 is answered locally with an error; a hung engine is aborted by a watchdog.
module root_engine_arbiter
  import root_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned D1_W    = DefD1W,
  parameter int unsigned D2_W    = DefD2W,
  parameter int unsigned OUT_W   = QOutW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*D1_W-1:0] req_data_1,
  input  logic [NUM_REQ*D2_W-1:0] req_data_2,
  output logic                    eng_in_valid,
  output logic [D1_W-1:0]         eng_in_data_1,
  output logic [D2_W-1:0]         eng_in_data_2,
  input  logic                    eng_out_valid,
  input  logic [OUT_W-1:0]        eng_out_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [D1_W-1:0]      op1_q, op1_d;
  logic [D2_W-1:0]      op2_q, op2_d;
  logic [OUT_W-1:0]     data_q, data_d;
  logic                 err_q, err_d;
  logic [TmoCntW-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      win_id;
  logic                 win_any;
  logic [D1_W-1:0]      req_d1 [NUM_REQ];
  logic [D2_W-1:0]      req_d2 [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (win_id),
    .any_o (win_any)
  );

  // Unpack the per-requester operand slices.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_d1[i] = req_data_1[i*D1_W +: D1_W];
      req_d2[i] = req_data_2[i*D2_W +: D2_W];
    end
  end

  // Next-state logic for the grant/issue/wait/respond sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          id_d  = win_id;
          op1_d = req_d1[win_id];
          op2_d = req_d2[win_id];
          if (req_d2[win_id] == '0) begin
            // Zeroth root is undefined: answer without touching the engine.
            data_d  = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        if (eng_out_valid) begin
          data_d  = eng_out_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == TmoCntW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant is only offered in IDLE; gated by rst so outputs read 0 during reset.
  assign req_ready     = (state_q == StIdle && !rst) ? gnt : '0;
  assign eng_in_valid  = (state_q == StIssue);
  assign eng_in_data_1 = op1_q;
  assign eng_in_data_2 = op2_q;
  assign rsp_valid     = (state_q == StResp);
  assign rsp_id        = id_q;
  assign rsp_data      = data_q;
  assign rsp_err       = err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_root_engine_arbiter.sv
// Self-checking bench: behavioural engine stub plus a response scoreboard.
module tb_root_engine_arbiter;

  localparam int unsigned NReq    = 4;
  localparam int unsigned Timeout = 255;

  typedef struct packed {
    logic [1:0]  id;
    logic [19:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_data_1;
  logic [11:0] req_data_2;
  logic        eng_in_valid;
  logic [9:0]  eng_in_data_1;
  logic [2:0]  eng_in_data_2;
  logic        eng_out_valid;
  logic [19:0] eng_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [19:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  logic [9:0]  d1_a [NReq];
  logic [2:0]  d2_a [NReq];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   eng_starts = 0;
  int   issue_cyc = 0;
  int   rsp_cyc = 0;
  int   eng_lat = 4;
  bit   stub_hang = 1'b0;
  int   inj_seq = 0;
  exp_t sbq [$];
  int   grant_log [$];

  assign req_data_1 = {d1_a[3], d1_a[2], d1_a[1], d1_a[0]};
  assign req_data_2 = {d2_a[3], d2_a[2], d2_a[1], d2_a[0]};

  root_engine_arbiter u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data_1    (req_data_1),
    .req_data_2    (req_data_2),
    .eng_in_valid  (eng_in_valid),
    .eng_in_data_1 (eng_in_data_1),
    .eng_in_data_2 (eng_in_data_2),
    .eng_out_valid (eng_out_valid),
    .eng_out_data  (eng_out_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference Q10.10 nth root (floor), valid for exponents 1..3.
  function automatic logic [19:0] q_root(input logic [9:0] x, input logic [2:0] n);
    longint unsigned lim, p, t;
    logic [19:0] r;
    r = '0;
    if (n == 0) return r;
    lim = 64'(x) << (10 * int'(n));
    for (int b = 19; b >= 0; b--) begin
      t = 64'(r) | (64'd1 << b);
      p = 1;
      for (int k = 0; k < int'(n); k++) p = p * t;
      if (p <= lim) r = 20'(t);
    end
    return r;
  endfunction

  // Engine stub: fixed latency, or never answers when stub_hang is set.
  initial begin
    int left;
    int inj_done;
    logic [9:0] c1;
    logic [2:0] c2;
    left = 0;
    inj_done = 0;
    c1 = '0;
    c2 = '0;
    eng_out_valid = 1'b0;
    eng_out_data = '0;
    forever begin
      @(negedge clk);
      eng_out_valid = 1'b0;
      eng_out_data = '0;
      if (rst) begin
        left = 0;
      end else if (inj_seq != inj_done) begin
        inj_done = inj_seq;
        eng_out_valid = 1'b1;
        eng_out_data = 20'hABCDE;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          check_eq("eng_op_hold", {19'd0, eng_in_data_1, eng_in_data_2}, {19'd0, c1, c2});
          eng_out_valid = 1'b1;
          eng_out_data = q_root(c1, c2);
        end
      end else if (eng_in_valid) begin
        c1 = eng_in_data_1;
        c2 = eng_in_data_2;
        if (!stub_hang) left = eng_lat;
      end
    end
  end

  // Monitor: push expectations on acceptance, pop and compare on response handshake.
  initial begin
    bit prev_rdy;
    bit prev_rv;
    exp_t e;
    int id;
    prev_rdy = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sbq.delete();
        prev_rdy = 1'b0;
        prev_rv = 1'b0;
      end else begin
        if (prev_rdy) check_eq("ready_pulse", {28'd0, req_ready}, 32'd0);
        if (req_ready != '0) begin
          check_eq("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
          id = 0;
          for (int i = 0; i < int'(NReq); i++) if (req_ready[i]) id = i;
          e.id = 2'(id);
          e.err = (d2_a[id] == 0) || stub_hang;
          e.data = e.err ? 20'd0 : q_root(d1_a[id], d2_a[id]);
          sbq.push_back(e);
          grant_log.push_back(id);
        end
        prev_rdy = (req_ready != '0);
        if (eng_in_valid) begin
          eng_starts++;
          issue_cyc = cyc;
        end
        if (rsp_valid && !prev_rv) rsp_cyc = cyc;
        prev_rv = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          if (sbq.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check_eq("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
            check_eq("rsp_data", {12'd0, rsp_data}, {12'd0, e.data});
            check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          end
        end
      end
    end
  end

  task automatic request(input int id, input logic [9:0] a, input logic [2:0] b);
    bit ok;
    @(posedge clk);
    #1;
    d1_a[id] = a;
    d2_a[id] = b;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (!ok) check_eq("req_accept_tmo", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (!busy && !rsp_valid && sbq.size() == 0) ok = 1'b1;
    end
    if (!ok) check_eq("idle_tmo", 32'd0, 32'd1);
  endtask

  initial begin
    int starts0;
    int lat;
    bit ok;
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NReq); i++) begin
      d1_a[i] = 10'(10 + i);
      d2_a[i] = 3'd1;
    end
    req_valid = 4'hF;

    // Reset state, with every requester already asserting.
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_eng_in_valid", {31'd0, eng_in_valid}, 32'd0);
    check_eq("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check_eq("rst_rsp_data", {12'd0, rsp_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous requests: grant order 0,1,2,3,0.
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= 5) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    check_eq("grant_count", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check_eq($sformatf("grant_order%0d", i), 32'(grant_log[i]), 32'(i % 4));
    wait_idle();

    // Square root of 4 -> 2.0, exactly one engine start.
    starts0 = eng_starts;
    request(0, 10'd4, 3'd2);
    wait_idle();
    check_eq("sqrt4_starts", 32'(eng_starts - starts0), 32'd1);

    // Cube root of 8 under 10 cycles of response backpressure.
    rsp_ready = 1'b0;
    request(2, 10'd8, 3'd3);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    check_eq("bp_rsp_seen", {31'd0, ok}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_hold_data", {12'd0, rsp_data}, 32'h00800);
      check_eq("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("idle_after_accept", {31'd0, busy}, 32'd0);
    wait_idle();

    // Exponent 1 passthrough, then exponent 0 answered locally.
    request(1, 10'd5, 3'd1);
    wait_idle();
    starts0 = eng_starts;
    request(3, 10'd7, 3'd0);
    lat = 1;
    ok = rsp_valid;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) ok = 1'b1;
    end
    check_eq("exp0_latency_le3", {31'd0, (ok && lat <= 3)}, 32'd1);
    wait_idle();
    check_eq("exp0_no_start", 32'(eng_starts - starts0), 32'd0);

    // Hung engine: ISSUE cycle plus TIMEOUT BUSY cycles before the error response.
    stub_hang = 1'b1;
    request(1, 10'd7, 3'd2);
    wait_idle();
    check_eq("timeout_cycles", 32'(rsp_cyc - issue_cyc), 32'(Timeout + 1));
    inj_seq++;
    repeat (3) @(negedge clk);
    check_eq("late_pulse_busy", {31'd0, busy}, 32'd0);
    check_eq("late_pulse_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset while BUSY clears everything asynchronously and restarts the pointer.
    request(3, 10'd9, 3'd2);
    repeat (5) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_rsp_id", {30'd0, rsp_id}, 32'd0);
    check_eq("arst_eng_data", {19'd0, eng_in_data_1, eng_in_data_2}, 32'd0);
    check_eq("arst_rsp", {11'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
    repeat (2) @(negedge clk);
    stub_hang = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d1_a[0] = 10'd27;
    d2_a[0] = 3'd3;
    d1_a[2] = 10'd16;
    d2_a[2] = 3'd2;
    req_valid = 4'b0101;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (req_ready != '0) ok = 1'b1;
    end
    check_eq("grant_after_rst", {28'd0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[2]) ok = 1'b1;
    end
    check_eq("second_grant", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_idle();

    // Random single requests with varying engine latency.
    for (int n = 0; n < 6; n++) begin
      eng_lat = int'($urandom_range(1, 6));
      request(int'($urandom_range(0, 3)), 10'($urandom), 3'($urandom_range(1, 3)));
      wait_idle();
    end

    check_eq("sb_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
